// File: rtl/framebuffer_scanout_if.sv
// Framebuffer RAM read port: address out, byte back one clock later.
// master is the scanout engine, slave is the RAM.
interface framebuffer_scanout_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] read_address;
    logic [7:0]        q;

    modport master (output read_address, input q);
    modport slave  (input read_address, output q);
endinterface

// File: rtl/framebuffer_scanout.sv
// 640x480@60 scanout of a 320x240 1-bpp framebuffer, pixels doubled 2x2.
// Every output lags the beam counters by exactly three clocks.
module framebuffer_scanout #(
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int RAM_ADDRESS_SIZE = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    framebuffer_scanout_if.master ram,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  pixel,
    output logic                  frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int AW      = RAM_ADDRESS_SIZE + 1;
    localparam int HS_LO   = H_VISIBLE + H_FRONT;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_VISIBLE + V_FRONT;
    localparam int VS_HI   = VS_LO + V_SYNC;

    logic [9:0]    hc, vc, vc_next;
    logic          h_last, v_last;
    logic [9:0]    fetch_line;
    logic [AW-1:0] row, base, col;
    logic          fetch;
    logic [AW-1:0] rd_addr;
    logic [3:0]    hc_lo_d1;
    logic [7:0]    shreg;
    // bundles are {frame_start, vsync, hsync, de}
    logic [3:0]    tim0, tim_d1, tim_d2;

    assign h_last  = hc == 10'(H_TOTAL - 1);
    assign v_last  = vc == 10'(V_TOTAL - 1);
    assign vc_next = v_last ? 10'd0 : vc + 10'd1;

    // Beam position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= h_last ? 10'd0 : hc + 10'd1;
            if (h_last) vc <= vc_next;
        end
    end

    // Fetch byte k one clock before its first pixel: at hc=16k-1,
    // or at the previous line's last clock for byte 0.
    always_comb begin
        fetch_line = h_last ? vc_next : vc;
        row        = AW'(fetch_line >> 1);
        base       = (row << 5) + (row << 3);
        col        = h_last ? '0 : AW'((hc + 10'd1) >> 4);
        fetch      = (fetch_line < 10'(V_VISIBLE)) &&
                     (h_last || (hc[3:0] == 4'hf &&
                                 hc < 10'(H_VISIBLE - 1)));
    end

    // Read address register; holds through blanking
    always_ff @(posedge clk) begin
        if (reset) rd_addr <= '0;
        else if (fetch) rd_addr <= base + col;
    end

    assign ram.read_address = rd_addr;

    assign tim0 = {
        hc == 10'd0 && vc == 10'd0,
        !(vc >= 10'(VS_LO) && vc < 10'(VS_HI)),
        !(hc >= 10'(HS_LO) && hc < 10'(HS_HI)),
        hc < 10'(H_VISIBLE) && vc < 10'(V_VISIBLE)
    };

    // Delay timing two clocks to line up with the shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_lo_d1 <= '0;
            tim_d1   <= 4'b0110;
            tim_d2   <= 4'b0110;
        end else begin
            hc_lo_d1 <= hc[3:0];
            tim_d1   <= tim0;
            tim_d2   <= tim_d1;
        end
    end

    // Load on the byte's first pixel, then shift every second clock
    always_ff @(posedge clk) begin
        if (reset) shreg <= '0;
        else if (hc_lo_d1 == 4'd0) shreg <= ram.q;
        else if (!hc_lo_d1[0]) shreg <= {shreg[6:0], 1'b0};
    end

    // Registered VGA outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pixel       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tim_d2[3];
            vsync       <= tim_d2[2];
            hsync       <= tim_d2[1];
            de          <= tim_d2[0];
            pixel       <= tim_d2[0] & shreg[7];
        end
    end
endmodule
